// File: rtl/best_score_seq.sv
// best_score_seq: streaming signed running-minimum selector over a frame of candidate beats with registered result handshake.
module best_score_seq #(
  parameter int SCORE_W  = 64,
  parameter int MAX_CAND = 10,
  parameter int MODE_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SCORE_W-1:0] in_score,
  input  logic                      in_en,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MODE_W-1:0]         out_mode,
  output logic signed [SCORE_W-1:0] out_score,
  output logic                      out_none,
  output logic                      out_ovf
);
  // idx is one bit wider than a mode index so it can saturate at MAX_CAND == 2**MODE_W
  localparam logic [MODE_W:0] LIM = (MODE_W+1)'(MAX_CAND);
  typedef enum logic {ACC, DONE} state_t;
  state_t state, state_n;
  logic [MODE_W:0] idx;
  logic [MODE_W-1:0] best_idx;
  logic signed [SCORE_W-1:0] best_score;
  logic have_best, ovf, fire, over, take;
  assign in_ready  = state == ACC;
  assign out_valid = state == DONE;
  assign fire = in_valid && in_ready;
  assign over = idx >= LIM;
  assign take = in_en && !over && (!have_best || in_score < best_score);
  always_ff @(posedge clk)
    state <= rst ? ACC : state_n;
  always_comb begin
    state_n = state;
    state_n = (state == ACC) ? ((fire && in_last) ? DONE : ACC) : (out_ready ? ACC : DONE);
  end
  // best_idx/best_score stay zero while have_best is clear, which gives the "none" encoding for free
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      have_best <= 1'b0;
      best_idx <= '0;
      best_score <= '0;
      ovf <= 1'b0;
      out_mode <= '0;
      out_score <= '0;
      out_none <= 1'b0;
      out_ovf <= 1'b0;
    end else if (fire) begin
      idx <= over ? idx : idx + 1'b1;
      if (take) begin
        best_idx <= idx[MODE_W-1:0];
        best_score <= in_score;
        have_best <= 1'b1;
      end
      if (over) ovf <= 1'b1;
      if (in_last) begin
        out_mode <= take ? idx[MODE_W-1:0] : best_idx;
        out_score <= take ? in_score : best_score;
        out_none <= !(have_best || take);
        out_ovf <= ovf || over;
      end
    end else if (out_valid && out_ready) begin
      idx <= '0;
      have_best <= 1'b0;
      best_idx <= '0;
      best_score <= '0;
      ovf <= 1'b0;
    end
  end
endmodule
